// File: rtl/mcdma_s2mm_arbiter.sv
// Packet-atomic round-robin merge of NUM_CH AXI-Stream producers onto one
// S2MM stream, with a two-entry registered skid buffer on the output.
`timescale 1ns/1ps

module mcdma_s2mm_arbiter #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TDEST_W = 4,
    parameter int unsigned TID_W   = 16,
    parameter int unsigned TUSER_W = 16
) (
    input  logic                            clk100mhz_0,
    input  logic                            peripheral_reset_0,
    input  logic [NUM_CH*DATA_W-1:0]        src_tdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0]    src_tkeep,
    input  logic [NUM_CH*TUSER_W-1:0]       src_tuser,
    input  logic [NUM_CH-1:0]               src_tlast,
    input  logic [NUM_CH-1:0]               src_tvalid,
    output logic [NUM_CH-1:0]               src_tready,
    input  logic [NUM_CH-1:0]               ch_enable,
    output logic [DATA_W-1:0]               S_AXIS_S2MM_0_tdata,
    output logic [DATA_W/8-1:0]             S_AXIS_S2MM_0_tkeep,
    output logic [TUSER_W-1:0]              S_AXIS_S2MM_0_tuser,
    output logic [TDEST_W-1:0]              S_AXIS_S2MM_0_tdest,
    output logic [TID_W-1:0]                S_AXIS_S2MM_0_tid,
    output logic                            S_AXIS_S2MM_0_tlast,
    output logic                            S_AXIS_S2MM_0_tvalid,
    input  logic                            S_AXIS_S2MM_0_tready,
    output logic                            grant_valid,
    output logic [$clog2(NUM_CH)-1:0]       grant_ch
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned GCH_W  = $clog2(NUM_CH);

    // One buffered beat; channel index becomes tdest/tid on the way out.
    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [KEEP_W-1:0]  keep;
        logic [TUSER_W-1:0] user;
        logic [GCH_W-1:0]   ch;
        logic               last;
    } beat_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             r_state;
    logic [GCH_W-1:0]   r_grant_ch;
    logic [GCH_W-1:0]   r_last_grant;
    logic               r_grant_valid;
    logic [NUM_CH-1:0]  r_src_tready;

    beat_t              r_out;
    logic               r_out_valid;
    beat_t              r_skid;
    logic               r_skid_valid;

    beat_t              w_in;
    beat_t              w_out_nxt;
    beat_t              w_skid_nxt;
    logic               w_out_valid_nxt;
    logic               w_skid_valid_nxt;
    logic               w_can_accept_nxt;
    logic               w_push;
    logic               w_pop;
    logic [NUM_CH-1:0]  w_req;
    logic [GCH_W-1:0]   w_winner;
    logic [NUM_CH-1:0]  w_win_oh;
    logic [NUM_CH-1:0]  w_grant_oh;

    // First requesting channel searching upward from last+1, wrapping.
    function automatic logic [GCH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                  input logic [GCH_W-1:0]  last);
        logic [GCH_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = 32'(last) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && req[GCH_W'(idx)]) begin
                pick  = GCH_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Arbitration inputs and the granted channel's current beat.
    always_comb begin
        w_req      = src_tvalid & ch_enable;
        w_winner   = rr_pick(w_req, r_last_grant);
        w_win_oh   = NUM_CH'(1) << w_winner;
        w_grant_oh = NUM_CH'(1) << r_grant_ch;
        w_in.data  = src_tdata[32'(r_grant_ch)*DATA_W +: DATA_W];
        w_in.keep  = src_tkeep[32'(r_grant_ch)*KEEP_W +: KEEP_W];
        w_in.user  = src_tuser[32'(r_grant_ch)*TUSER_W +: TUSER_W];
        w_in.ch    = r_grant_ch;
        w_in.last  = src_tlast[r_grant_ch];
        w_push     = |(src_tvalid & r_src_tready);
        w_pop      = r_out_valid & S_AXIS_S2MM_0_tready;
    end

    // Skid buffer next state: output register refills from skid first, then input.
    always_comb begin
        w_out_nxt        = r_out;
        w_out_valid_nxt  = r_out_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (!r_out_valid || w_pop) begin
            if (r_skid_valid) begin
                w_out_nxt        = r_skid;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = w_push;
                if (w_push) begin
                    w_skid_nxt = w_in;
                end
            end else if (w_push) begin
                w_out_nxt       = w_in;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_push) begin
            w_skid_nxt       = w_in;
            w_skid_valid_nxt = 1'b1;
        end
        w_can_accept_nxt = !(w_out_valid_nxt && w_skid_valid_nxt);
    end

    // Skid buffer storage; reset drops anything in flight.
    always_ff @(posedge clk100mhz_0 or posedge peripheral_reset_0) begin
        if (peripheral_reset_0) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            r_out        <= w_out_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid       <= w_skid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
        end
    end

    // Grant FSM; src_tready is registered from next-cycle buffer occupancy.
    always_ff @(posedge clk100mhz_0 or posedge peripheral_reset_0) begin
        if (peripheral_reset_0) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= GCH_W'(NUM_CH - 1);
            r_grant_ch    <= '0;
            r_grant_valid <= 1'b0;
            r_src_tready  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_src_tready <= '0;
                    if (|w_req) begin
                        r_grant_ch    <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_state       <= ST_XFER;
                        r_src_tready  <= w_can_accept_nxt ? w_win_oh : '0;
                    end
                end
                ST_XFER: begin
                    if (w_push && w_in.last) begin
                        r_last_grant  <= r_grant_ch;
                        r_grant_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                        r_src_tready  <= '0;
                    end else begin
                        r_src_tready  <= w_can_accept_nxt ? w_grant_oh : '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign src_tready           = r_src_tready;
    assign grant_valid          = r_grant_valid;
    assign grant_ch             = r_grant_ch;
    assign S_AXIS_S2MM_0_tdata  = r_out.data;
    assign S_AXIS_S2MM_0_tkeep  = r_out.keep;
    assign S_AXIS_S2MM_0_tuser  = r_out.user;
    assign S_AXIS_S2MM_0_tdest  = TDEST_W'(r_out.ch);
    assign S_AXIS_S2MM_0_tid    = TID_W'(r_out.ch);
    assign S_AXIS_S2MM_0_tlast  = r_out.last;
    assign S_AXIS_S2MM_0_tvalid = r_out_valid;

endmodule

// File: tb/tb_mcdma_s2mm_arbiter.sv
// Bench for mcdma_s2mm_arbiter: queued packet sources, output monitor and a
// packet-level round-robin reference model.
`timescale 1ns/1ps

module tb_mcdma_s2mm_arbiter;

    localparam int NUM_CH = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [15:0] user;
        logic        last;
    } sbeat_t;

    typedef struct packed {
        logic [3:0]  dest;
        logic [15:0] tid;
        logic [31:0] data;
        logic [3:0]  keep;
        logic [15:0] user;
        logic        last;
    } obeat_t;

    typedef struct {
        int cyc;
        int ch;
        bit first;
        bit last;
    } acc_t;

    logic          clk;
    logic          rst;
    logic [127:0]  src_tdata;
    logic [15:0]   src_tkeep;
    logic [63:0]   src_tuser;
    logic [3:0]    src_tlast;
    logic [3:0]    src_tvalid;
    logic [3:0]    src_tready;
    logic [3:0]    ch_enable;
    logic [31:0]   m_tdata;
    logic [3:0]    m_tkeep;
    logic [15:0]   m_tuser;
    logic [3:0]    m_tdest;
    logic [15:0]   m_tid;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic          grant_valid;
    logic [1:0]    grant_ch;

    mcdma_s2mm_arbiter #(
        .NUM_CH(4), .DATA_W(32), .TDEST_W(4), .TID_W(16), .TUSER_W(16)
    ) dut (
        .clk100mhz_0          (clk),
        .peripheral_reset_0   (rst),
        .src_tdata            (src_tdata),
        .src_tkeep            (src_tkeep),
        .src_tuser            (src_tuser),
        .src_tlast            (src_tlast),
        .src_tvalid           (src_tvalid),
        .src_tready           (src_tready),
        .ch_enable            (ch_enable),
        .S_AXIS_S2MM_0_tdata  (m_tdata),
        .S_AXIS_S2MM_0_tkeep  (m_tkeep),
        .S_AXIS_S2MM_0_tuser  (m_tuser),
        .S_AXIS_S2MM_0_tdest  (m_tdest),
        .S_AXIS_S2MM_0_tid    (m_tid),
        .S_AXIS_S2MM_0_tlast  (m_tlast),
        .S_AXIS_S2MM_0_tvalid (m_tvalid),
        .S_AXIS_S2MM_0_tready (m_tready),
        .grant_valid          (grant_valid),
        .grant_ch             (grant_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_chk;
    int     n_err;
    sbeat_t src_q[NUM_CH][$];
    obeat_t exp_q[$];
    obeat_t out_q[$];
    int     out_cyc[$];
    acc_t   acc_q[$];
    bit     in_pkt[NUM_CH];
    bit     pend[NUM_CH];
    int     cyc;
    int     gv_cnt;
    int     tv_cnt;
    int     tv_first;
    int     viol;
    bit     gap_en;
    int     rdy_mode;
    bit     clr3_hook;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return {m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tdest, m_tid,
                src_tready, grant_valid, grant_ch};
    endfunction

    task automatic add_pkt(input int c, input int len, input logic [31:0] base);
        sbeat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + 32'(k);
            b.keep = 4'($urandom);
            b.user = 16'($urandom);
            b.last = (k == len - 1);
            src_q[c].push_back(b);
        end
    endtask

    // AXIS sources: tvalid held once raised; gaps only mid-packet.
    task automatic drive_inputs();
        for (int c = 0; c < NUM_CH; c++) begin
            bit v;
            v = (src_q[c].size() != 0);
            if (v && gap_en && in_pkt[c] && !pend[c] && $urandom_range(0, 3) == 0) v = 1'b0;
            src_tvalid[c] = v;
            if (src_q[c].size() != 0) begin
                src_tdata[c*32 +: 32] = src_q[c][0].data;
                src_tkeep[c*4 +: 4]   = src_q[c][0].keep;
                src_tuser[c*16 +: 16] = src_q[c][0].user;
                src_tlast[c]          = src_q[c][0].last;
            end else begin
                src_tdata[c*32 +: 32] = '0;
                src_tkeep[c*4 +: 4]   = '0;
                src_tuser[c*16 +: 16] = '0;
                src_tlast[c]          = 1'b0;
            end
        end
        case (rdy_mode)
            1:       m_tready = (cyc % 2 == 0);
            2:       m_tready = ($urandom_range(0, 2) != 0);
            default: m_tready = 1'b1;
        endcase
    endtask

    // One clock: drive, sample at negedge, apply handshakes after posedge.
    task automatic step();
        logic [3:0] acc;
        bit         fire;
        bit         stall;
        obeat_t     snap;
        obeat_t     now;
        sbeat_t     b;
        acc_t       a;
        drive_inputs();
        @(negedge clk);
        acc   = src_tvalid & src_tready;
        fire  = m_tvalid & m_tready;
        stall = m_tvalid & !m_tready;
        snap  = {m_tdest, m_tid, m_tdata, m_tkeep, m_tuser, m_tlast};
        if ($countones(src_tready) > 1) viol++;
        if (!grant_valid && src_tready != 4'b0) viol++;
        if (grant_valid) gv_cnt++;
        if (m_tvalid) begin
            tv_cnt++;
            if (tv_first < 0) tv_first = cyc;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            pend[c] = src_tvalid[c] && !acc[c];
            if (acc[c]) begin
                b       = src_q[c].pop_front();
                a.cyc   = cyc;
                a.ch    = c;
                a.first = !in_pkt[c];
                a.last  = b.last;
                acc_q.push_back(a);
                in_pkt[c] = !b.last;
                if (clr3_hook && c == 3) ch_enable[3] = 1'b0;
            end
        end
        if (fire) begin
            out_q.push_back(snap);
            out_cyc.push_back(cyc);
        end
        if (stall) begin
            now = {m_tdest, m_tid, m_tdata, m_tkeep, m_tuser, m_tlast};
            check("hold", {m_tvalid, now}, {1'b1, snap});
        end
        cyc++;
    endtask

    task automatic reset_begin();
        rst = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            src_q[c].delete();
            in_pkt[c] = 1'b0;
            pend[c]   = 1'b0;
        end
        out_q.delete();
        out_cyc.delete();
        exp_q.delete();
        acc_q.delete();
        src_tvalid = '0;
        ch_enable  = 4'hF;
        gv_cnt     = 0;
        tv_cnt     = 0;
        tv_first   = -1;
        clr3_hook  = 1'b0;
        gap_en     = 1'b0;
        rdy_mode   = 0;
        cyc        = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_release();
        cyc = 0;
        drive_inputs();
        rst = 1'b0;
    endtask

    // Packet-level reference: round-robin over enabled channels with pending packets.
    task automatic build_exp(input logic [3:0] mask, input int clr_ch);
        sbeat_t     m[NUM_CH][$];
        sbeat_t     b;
        obeat_t     o;
        logic [3:0] mk;
        int         last;
        int         pick;
        bit         done;
        for (int c = 0; c < NUM_CH; c++) m[c] = src_q[c];
        mk   = mask;
        last = NUM_CH - 1;
        done = 1'b0;
        exp_q.delete();
        while (!done) begin
            pick = -1;
            for (int k = 1; k <= NUM_CH; k++) begin
                int c;
                c = (last + k) % NUM_CH;
                if (pick < 0 && mk[c] && m[c].size() > 0) pick = c;
            end
            if (pick < 0) begin
                done = 1'b1;
            end else begin
                do begin
                    b = m[pick].pop_front();
                    o = {4'(pick), 16'(pick), b.data, b.keep, b.user, b.last};
                    exp_q.push_back(o);
                end while (!b.last && m[pick].size() > 0);
                last = pick;
                if (pick == clr_ch) mk[pick] = 1'b0;
            end
        end
    endtask

    task automatic run_check(input string tag, input int budget);
        int k;
        int n;
        k = 0;
        while (out_q.size() < exp_q.size() && k < budget) begin
            step();
            k++;
        end
        check({tag, "_count"}, out_q.size(), exp_q.size());
        repeat (4) step();
        check({tag, "_extra"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_beat"}, out_q[i], exp_q[i]);
    endtask

    task automatic check_spacing(input string tag);
        for (int i = 1; i < acc_q.size(); i++)
            check(tag, acc_q[i].cyc - acc_q[i-1].cyc, acc_q[i].first ? 2 : 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] seq;
        logic [3:0]  mask;
        int          n2;
        n_chk = 0; n_err = 0; viol = 0; cyc = 0;
        rst = 1'b1; m_tready = 1'b0; ch_enable = '0;
        src_tdata = '0; src_tkeep = '0; src_tuser = '0; src_tlast = '0; src_tvalid = '0;

        // Reset values
        reset_begin();
        check("reset_outputs", out_vec(), 128'd0);

        // Single 3-beat packet on channel 2
        reset_begin();
        add_pkt(2, 3, 32'hA0);
        reset_release();
        build_exp(4'hF, -1);
        run_check("single", 50);
        check("single_arb_lat", (acc_q.size() > 0) ? acc_q[0].cyc : -1, 1);
        check("single_out_lat", tv_first, (acc_q.size() > 0) ? acc_q[0].cyc + 1 : -99);
        check("single_consec", (out_cyc.size() == 3) ? out_cyc[2] - out_cyc[0] : -1, 2);

        // Round-robin order with one bubble between packets
        reset_begin();
        for (int c = 0; c < NUM_CH; c++) add_pkt(c, 2, 32'h100 * (c + 1));
        add_pkt(0, 2, 32'h500);
        reset_release();
        build_exp(4'hF, -1);
        run_check("rr", 100);
        seq = '0;
        foreach (out_q[i]) if (out_q[i].last) seq = {seq[15:0], out_q[i].dest};
        check("rr_order", seq, 20'h01230);
        check_spacing("rr_spacing");

        // Backpressure with tready toggling
        reset_begin();
        rdy_mode = 1;
        add_pkt(1, 6, 32'hB0);
        reset_release();
        build_exp(4'hF, -1);
        run_check("bp", 100);

        // Enable mask 1011, channel 3 cleared mid-packet
        reset_begin();
        ch_enable = 4'b1011;
        clr3_hook = 1'b1;
        for (int c = 0; c < NUM_CH; c++) add_pkt(c, 3, 32'hC00 + 32'h10 * c);
        add_pkt(0, 2, 32'hCF0);
        reset_release();
        build_exp(4'b1011, 3);
        run_check("en", 100);
        seq = '0;
        n2  = 0;
        foreach (out_q[i]) begin
            if (out_q[i].dest == 4'd2) n2++;
            if (out_q[i].last) seq = {seq[15:0], out_q[i].dest};
        end
        check("en_order", seq, 20'h00130);
        check("en_no_ch2", n2, 0);
        check("en_ch2_waiting", src_q[2].size(), 3);

        // Reset in the middle of a channel 0 packet
        reset_begin();
        add_pkt(0, 4, 32'hD0);
        reset_release();
        for (int k = 0; k < 20 && acc_q.size() < 2; k++) step();
        check("rstmid_reach", acc_q.size(), 2);
        rst = 1'b1;
        #1;
        check("rstmid_outputs", out_vec(), 128'd0);
        reset_begin();
        add_pkt(0, 2, 32'hE0);
        add_pkt(1, 2, 32'hE8);
        reset_release();
        build_exp(4'hF, -1);
        run_check("rstmid_after", 50);
        check("rstmid_first_ch", (out_q.size() > 0) ? out_q[0].dest : 4'hF, 4'd0);

        // Full throughput 16-beat packet
        reset_begin();
        add_pkt($urandom_range(0, 3), 16, $urandom);
        reset_release();
        build_exp(4'hF, -1);
        run_check("tp", 100);
        check("tp_tvalid_cycles", tv_cnt, 16);
        check("tp_span", (out_cyc.size() == 16) ? out_cyc[15] - out_cyc[0] : -1, 15);
        check("tp_grant_cycles", gv_cnt, 16);
        check_spacing("tp_spacing");

        // Randomized traffic, masks, gaps and backpressure
        for (int r = 0; r < 6; r++) begin
            reset_begin();
            gap_en   = 1'b1;
            rdy_mode = 2;
            mask     = 4'($urandom_range(1, 15));
            ch_enable = mask;
            for (int c = 0; c < NUM_CH; c++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) add_pkt(c, $urandom_range(1, 5), $urandom);
            end
            add_pkt($urandom_range(0, 3), $urandom_range(1, 5), $urandom);
            reset_release();
            build_exp(mask, -1);
            run_check("rnd", 3000);
        end

        check("ready_onehot_and_gated", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mcdma_s2mm_arbiter.md
# mcdma_s2mm_arbiter

Packet-atomic round-robin arbiter that merges NUM_CH AXI-Stream producers inside the reconfigurable partition onto the single S2MM stream of the multichannel DMA. Each packet is tagged with its channel number on tdest/tid so the DMA routes it to the matching S2MM channel. A registered skid-buffer output stage keeps full one-beat-per-cycle throughput inside a packet and registers every output.

## Interface
Parameters:
- NUM_CH, 4: number of producer channels, 2..16.
- DATA_W, 32: tdata width; tkeep width is DATA_W/8.
- TDEST_W, 4: output tdest width; NUM_CH <= 2**TDEST_W.
- TID_W, 16: output tid width.
- TUSER_W, 16: tuser width, passed through unchanged.

Ports:
- clk100mhz_0  in  1  clock.
- peripheral_reset_0  in  1  asynchronous, active-high reset.
- src_tdata  in  NUM_CH*DATA_W  channel i occupies slice [i*DATA_W +: DATA_W].
- src_tkeep  in  NUM_CH*DATA_W/8  per-channel byte enables.
- src_tuser  in  NUM_CH*TUSER_W  per-channel user sideband.
- src_tlast  in  NUM_CH  per-channel end of packet.
- src_tvalid  in  NUM_CH  per-channel beat valid.
- src_tready  out  NUM_CH  per-channel ready; at most one bit high per cycle.
- ch_enable  in  NUM_CH  channel i is eligible for a new grant only while bit i = 1.
- S_AXIS_S2MM_0_tdata  out  DATA_W  merged stream data to the DMA.
- S_AXIS_S2MM_0_tkeep  out  DATA_W/8.
- S_AXIS_S2MM_0_tuser  out  TUSER_W.
- S_AXIS_S2MM_0_tdest  out  TDEST_W  granted channel index.
- S_AXIS_S2MM_0_tid  out  TID_W  granted channel index, zero-extended.
- S_AXIS_S2MM_0_tlast  out  1.
- S_AXIS_S2MM_0_tvalid  out  1.
- S_AXIS_S2MM_0_tready  in  1  backpressure from the DMA.
- grant_valid  out  1  high in XFER.
- grant_ch  out  $clog2(NUM_CH)  current or last granted channel.

## Operation
- The FSM has two states, IDLE and XFER.
- **IDLE:**
  - Form the request vector req = src_tvalid & ch_enable.
  - If req != 0, grant the first set bit searching upward from (last_grant+1) mod NUM_CH, wrapping around.
  - Latch the winner into grant_ch and go to XFER.
  - All src_tready bits are 0 in IDLE.
- **XFER:**
  - src_tready[grant_ch] equals the skid buffer's "can accept" signal (buffer not full). All other ready bits are 0.
  - Each accepted beat (src_tvalid & src_tready) is pushed into the skid buffer with tdest = grant_ch and tid = grant_ch.
  - When a beat with tlast = 1 is accepted: last_grant <= grant_ch, then go to IDLE.
- **Packets are never interleaved.** A grant is held until tlast, with no timeout.
- **ch_enable** is sampled only in IDLE. Clearing a bit mid-packet does not abort that packet.
- **Skid buffer:** two entries.
  - The output registers drive S_AXIS_S2MM_0_* directly.
  - "Can accept" is true while fewer than 2 entries are occupied, computed from registered state only. There is no combinational path from S_AXIS_S2MM_0_tready to src_tready.
  - While tvalid = 1 and tready = 0, all output payload is held stable.
- **Reset:**
  - Values: FSM = IDLE, last_grant = NUM_CH-1 (so channel 0 wins first), skid buffer emptied, grant_ch = 0.
  - All outputs are 0: tvalid, tlast, tdata, tkeep, tuser, tdest, tid, src_tready, grant_valid.
  - Reset mid-packet discards any buffered beats. The partial packet is not completed.

## Timing
- Arbitration costs one cycle. The request is seen in IDLE in cycle N, and src_tready can first be 1 in cycle N+1.
- A source beat accepted in cycle N appears on S_AXIS_S2MM_0_tvalid in cycle N+1.
- Within a packet, throughput is 1 beat/cycle while S_AXIS_S2MM_0_tready = 1.
- Between back-to-back packets there is exactly one cycle with no source accepted (the IDLE cycle).
- A simultaneous tlast accept and new request from another channel: the new grant happens in the following IDLE cycle, never in the same cycle.
- grant_valid is high for exactly the XFER cycles.

## Test plan
- **Single packet:** channel 2 sends a 3-beat packet 0xA0, 0xA1, 0xA2 (tlast on the third beat), with S_AXIS_S2MM_0_tready = 1. Required: three consecutive output beats starting one cycle after the first accept, tdest = 2, tid = 2, tlast only on 0xA2.
- **Round-robin order:** all 4 channels hold 2-beat packets ready from the moment reset releases. Required: output channel order 0,1,2,3,0, with exactly one bubble cycle between packets.
- **Backpressure:** a 6-beat packet on channel 1 while S_AXIS_S2MM_0_tready toggles 1,0,1,0. Required: all 6 beats delivered in order with no loss or duplication, and payload stable during every tready = 0 cycle.
- **Enable mask:** ch_enable = 0b1011, and channel 3 clears its bit in the middle of its packet, while channels 0..3 all request. Required: channel 2 is never granted, and channel 3's in-flight packet completes.
- **Reset mid-packet:** assert reset at beat 2 of a 4-beat channel 0 packet. Required: all outputs are 0 immediately. After release with channels 0 and 1 requesting, channel 0 is granted first.
- **Full throughput:** a 16-beat packet with tready held at 1. Required: 16 consecutive S_AXIS_S2MM_0_tvalid cycles, and grant_valid high for exactly 16 cycles.
